// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if.sv
//
// Bus interfaces used around dmem_arbiter.
//
// dmem_req_if : one requester port of the arbiter.
//   req    requester -> arbiter  access request, held with fields stable
//                                until gnt (or dropped before gnt)
//   we     requester -> arbiter  1 = write, 0 = read
//   lock   requester -> arbiter  ask to keep the grant next cycle
//   addr   requester -> arbiter  byte address (word aligned)
//   wdata  requester -> arbiter  write data
//   gnt    arbiter -> requester  access accepted this cycle (combinational)
//   rvalid arbiter -> requester  one-cycle pulse, rdata valid
//   rdata  arbiter -> requester  registered read data
//   err    arbiter -> requester  one-cycle pulse, misaligned request rejected
//
// dmem_mem_if : connection to the single-port data memory.
//   we     arbiter -> memory     write enable, commits on posedge clk
//   a      arbiter -> memory     byte address
//   wd     arbiter -> memory     write data
//   rd     memory -> arbiter     combinational read data
// ---------------------------------------------------------------------------
interface dmem_req_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          err;

    // Requester side drives the request fields and observes the responses.
    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    // Arbiter side observes the request fields and drives the responses.
    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

interface dmem_mem_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;

    // The arbiter drives the memory address/write side.
    modport master (
        output we, a, wd,
        input  rd
    );

    // The memory returns read data for the presented address.
    modport slave (
        input  we, a, wd,
        output rd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter.sv
//
// Shares one single-port data memory between two requesters: port m0 (CPU
// load/store unit) and port m1 (debug/DMA loader). Conflicts are resolved
// round-robin; a requester may hold the grant for up to LOCK_MAX consecutive
// accesses via its lock input (read-modify-write sequences), after which the
// grant is forcibly passed on. Misaligned word accesses are rejected with a
// one-cycle err pulse instead of reaching memory. Read data is captured from
// the memory's combinational read port at the grant edge and presented one
// cycle later with an rvalid pulse.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  synchronous active-low reset
//   m0     requester 0 (dmem_req_if.slave)
//   m1     requester 1 (dmem_req_if.slave)
//   mem    data memory connection (dmem_mem_if.master)
//
// Parameters:
//   AW        byte address width
//   DW        data width
//   LOCK_MAX  maximum consecutive locked grants before forced release (>=1)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_req_if.slave   m0,
    dmem_req_if.slave   m1,
    dmem_mem_if.master  mem
);

    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LOCK_LIMIT = CW'(LOCK_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    // Arbitration state
    logic          prio;
    owner_t        owner;
    logic [CW-1:0] lock_cnt;

    // Registered responses
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          err0;
    logic          err1;

    // Winner selection and its muxed request fields
    logic          any_req;
    logic          win;
    logic          win_we;
    logic          win_lock;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          aligned;
    logic          grant;
    owner_t        win_owner;
    logic [CW-1:0] base_cnt;
    logic [CW-1:0] run_cnt;
    logic          keep_lock;

    // Pick the winner: a lock owner that is still requesting keeps the
    // grant, a lone requester wins outright, and a tie goes to prio.
    always_comb begin
        any_req = m0.req | m1.req;
        if (owner == OWN_M0 && m0.req) begin
            win = 1'b0;
        end else if (owner == OWN_M1 && m1.req) begin
            win = 1'b1;
        end else if (m0.req && !m1.req) begin
            win = 1'b0;
        end else if (m1.req && !m0.req) begin
            win = 1'b1;
        end else begin
            win = prio;
        end
    end

    // Mux the winner's request onto internal signals.
    always_comb begin
        win_we    = win ? m1.we    : m0.we;
        win_lock  = win ? m1.lock  : m0.lock;
        win_addr  = win ? m1.addr  : m0.addr;
        win_wdata = win ? m1.wdata : m0.wdata;
        aligned   = (win_addr[1:0] == 2'b00);
    end

    // A grant needs a request, an aligned address and no reset in progress;
    // gating with rst_n keeps a write from committing at a reset edge.
    assign grant = rst_n & any_req & aligned;

    assign m0.gnt = grant & ~win;
    assign m1.gnt = grant & win;

    // The memory only sees the winner while it is granted; otherwise the
    // bus rests at zero so nothing stray reaches dmem.
    assign mem.we = grant & win_we;
    assign mem.a  = grant ? win_addr  : '0;
    assign mem.wd = grant ? win_wdata : '0;

    // Lock bookkeeping: the consecutive-grant count only carries over when
    // the winner is the current owner, otherwise this is its first grant.
    // The lock continues only while the count stays below LOCK_MAX.
    always_comb begin
        win_owner = win ? OWN_M1 : OWN_M0;
        base_cnt  = (owner == win_owner) ? lock_cnt : '0;
        run_cnt   = base_cnt + CW'(1);
        keep_lock = win_lock && (run_cnt < LOCK_LIMIT);
    end

    // Arbitration state and registered responses. A rejected misaligned
    // request still advances prio/owner as if granted so the other port is
    // not starved by a stuck bad request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio     <= 1'b0;
            owner    <= OWN_NONE;
            lock_cnt <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            err0     <= 1'b0;
            err1     <= 1'b0;
        end else begin
            rvalid0 <= grant & ~win & ~win_we;
            rvalid1 <= grant &  win & ~win_we;
            err0    <= any_req & ~aligned & ~win;
            err1    <= any_req & ~aligned &  win;

            if (grant && !win_we) begin
                if (win) begin
                    rdata1 <= mem.rd;
                end else begin
                    rdata0 <= mem.rd;
                end
            end

            if (any_req) begin
                if (keep_lock) begin
                    owner    <= win_owner;
                    lock_cnt <= run_cnt;
                end else begin
                    owner    <= OWN_NONE;
                    lock_cnt <= '0;
                    prio     <= ~win;
                end
            end else begin
                owner    <= OWN_NONE;
                lock_cnt <= '0;
            end
        end
    end

    assign m0.rvalid = rvalid0;
    assign m0.rdata  = rdata0;
    assign m0.err    = err0;
    assign m1.rvalid = rvalid1;
    assign m1.rdata  = rdata1;
    assign m1.err    = err1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter.sv
//
// Bench for dmem_arbiter. A behavioural memory plays dmem. The driver sets
// inputs on the falling edge, checks the combinational grant/memory bus
// against a reference model of the arbitration rules, and pushes the
// expected registered response into a queue. A monitor samples just after
// each rising edge and pops/compares rvalid, err and rdata.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int LOCK_MAX = 4;

    logic clk;
    logic rst_n;

    dmem_req_if #(.AW(AW), .DW(DW)) m0_bus ();
    dmem_req_if #(.AW(AW), .DW(DW)) m1_bus ();
    dmem_mem_if #(.AW(AW), .DW(DW)) mem_bus ();

    dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .mem   (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dmem: combinational read, write on posedge.
    logic [DW-1:0] dmem [0:63];
    assign mem_bus.rd = dmem[mem_bus.a[7:2]];
    always @(posedge clk) begin
        if (mem_bus.we) dmem[mem_bus.a[7:2]] <= mem_bus.wd;
    end

    // Expected response: kind 0 = read data, 1 = err, 2 = reset
    typedef struct {
        int          port;
        int          kind;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_vec;
    int n_err;

    // Stimulus currently presented on each port
    logic        rst_v;
    logic        s_req  [2];
    logic        s_we   [2];
    logic        s_lock [2];
    logic [31:0] s_addr [2];
    logic [31:0] s_wd   [2];
    bit          resolved [2];

    // Reference model state
    logic [31:0] ref_mem [0:63];
    int          m_prio;
    int          m_owner;
    int          m_run;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic setPort(input int p, input logic req, input logic we, input logic lock,
                           input logic [31:0] addr, input logic [31:0] wd);
        s_req[p]  = req;
        s_we[p]   = we;
        s_lock[p] = lock;
        s_addr[p] = addr;
        s_wd[p]   = wd;
    endtask

    task automatic driveBus();
        rst_n        = rst_v;
        m0_bus.req   = s_req[0];
        m0_bus.we    = s_we[0];
        m0_bus.lock  = s_lock[0];
        m0_bus.addr  = s_addr[0];
        m0_bus.wdata = s_wd[0];
        m1_bus.req   = s_req[1];
        m1_bus.we    = s_we[1];
        m1_bus.lock  = s_lock[1];
        m1_bus.addr  = s_addr[1];
        m1_bus.wdata = s_wd[1];
    endtask

    // Reference model step for the current cycle: compares the
    // combinational outputs and queues the expected registered response.
    task automatic checkOutput();
        int          w;
        int          run;
        int          idx;
        logic        e_g0;
        logic        e_g1;
        logic        e_we;
        logic [31:0] e_a;
        logic [31:0] e_wd;
        exp_t        it;
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        e_we = 1'b0;
        e_a  = '0;
        e_wd = '0;
        resolved[0] = 1'b0;
        resolved[1] = 1'b0;
        if (!rst_v) begin
            m_prio  = 0;
            m_owner = -1;
            m_run   = 0;
            it.port = 0;
            it.kind = 2;
            it.data = '0;
            exp_q.push_back(it);
        end else if (s_req[0] || s_req[1]) begin
            if (m_owner >= 0 && s_req[m_owner]) w = m_owner;
            else if (s_req[0] && !s_req[1]) w = 0;
            else if (s_req[1] && !s_req[0]) w = 1;
            else w = m_prio;
            resolved[w] = 1'b1;
            it.port = w;
            if (s_addr[w] % 4 == 0) begin
                if (w == 0) e_g0 = 1'b1;
                else e_g1 = 1'b1;
                e_we = s_we[w];
                e_a  = s_addr[w];
                e_wd = s_wd[w];
                idx  = int'(s_addr[w] / 4) % 64;
                if (s_we[w]) begin
                    ref_mem[idx] = s_wd[w];
                end else begin
                    it.kind = 0;
                    it.data = ref_mem[idx];
                    exp_q.push_back(it);
                end
            end else begin
                it.kind = 1;
                it.data = '0;
                exp_q.push_back(it);
            end
            run = (m_owner == w) ? m_run + 1 : 1;
            if (s_lock[w] && run < LOCK_MAX) begin
                m_owner = w;
                m_run   = run;
            end else begin
                m_owner = -1;
                m_run   = 0;
                m_prio  = 1 - w;
            end
        end else begin
            m_owner = -1;
            m_run   = 0;
        end
        checkVal("m0_gnt", 32'(m0_bus.gnt), 32'(e_g0));
        checkVal("m1_gnt", 32'(m1_bus.gnt), 32'(e_g1));
        checkVal("mem_we", 32'(mem_bus.we), 32'(e_we));
        checkVal("mem_a", mem_bus.a, e_a);
        checkVal("mem_wd", mem_bus.wd, e_wd);
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        driveBus();
        #1;
        checkOutput();
    endtask

    task automatic newRandom(input int p);
        if (resolved[p] && s_lock[p] && $urandom_range(0, 3) != 0) begin
            s_req[p]  = 1'b1;
            s_lock[p] = ($urandom_range(0, 3) != 0);
        end else begin
            s_req[p]  = ($urandom_range(0, 3) != 0);
            s_lock[p] = ($urandom_range(0, 2) == 0);
        end
        s_we[p]   = 1'($urandom_range(0, 1));
        s_addr[p] = 32'($urandom_range(0, 63)) << 2;
        if ($urandom_range(0, 9) == 0) s_addr[p][1:0] = 2'($urandom_range(1, 3));
        s_wd[p]   = $urandom;
    endtask

    // Monitor: after every rising edge, compare registered responses with
    // whatever the model queued for this edge.
    initial begin
        logic [31:0] h0;
        logic [31:0] h1;
        logic        e_v0;
        logic        e_v1;
        logic        e_e0;
        logic        e_e1;
        exp_t        it;
        h0 = '0;
        h1 = '0;
        forever begin
            @(posedge clk);
            #1;
            e_v0 = 1'b0;
            e_v1 = 1'b0;
            e_e0 = 1'b0;
            e_e1 = 1'b0;
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                if (it.kind == 2) begin
                    h0 = '0;
                    h1 = '0;
                end else if (it.kind == 1) begin
                    if (it.port == 0) e_e0 = 1'b1;
                    else e_e1 = 1'b1;
                end else begin
                    if (it.port == 0) begin
                        e_v0 = 1'b1;
                        h0   = it.data;
                    end else begin
                        e_v1 = 1'b1;
                        h1   = it.data;
                    end
                end
            end
            checkVal("m0_rvalid", 32'(m0_bus.rvalid), 32'(e_v0));
            checkVal("m1_rvalid", 32'(m1_bus.rvalid), 32'(e_v1));
            checkVal("m0_err", 32'(m0_bus.err), 32'(e_e0));
            checkVal("m1_err", 32'(m1_bus.err), 32'(e_e1));
            checkVal("m0_rdata", m0_bus.rdata, h0);
            checkVal("m1_rdata", m1_bus.rdata, h1);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 32'hC0DE0000 | 32'(i);
            dmem[i]    = 32'hC0DE0000 | 32'(i);
        end
        m_prio  = 0;
        m_owner = -1;
        m_run   = 0;
        rst_v   = 1'b0;
        resolved[0] = 1'b0;
        resolved[1] = 1'b0;
        setPort(0, 0, 0, 0, '0, '0);
        setPort(1, 0, 0, 0, '0, '0);
        driveBus();

        // Reset and one idle cycle
        applyStimulus();
        applyStimulus();
        rst_v = 1'b1;
        applyStimulus();

        // m0 write then read back
        setPort(0, 1, 1, 0, 32'h4, 32'hAABBCCDD);
        applyStimulus();
        checkVal("t1_wr_gnt", 32'(m0_bus.gnt), 32'd1);
        setPort(0, 1, 0, 0, 32'h4, 32'h0);
        applyStimulus();
        checkVal("t1_rd_gnt", 32'(m0_bus.gnt), 32'd1);
        setPort(0, 0, 0, 0, 32'h0, 32'h0);
        @(posedge clk);
        #2;
        checkVal("t1_rvalid", 32'(m0_bus.rvalid), 32'd1);
        checkVal("t1_rdata", m0_bus.rdata, 32'hAABBCCDD);

        // Preload 0x8 through m1, then both read together: grants alternate
        setPort(1, 1, 1, 0, 32'h8, 32'h11223344);
        applyStimulus();
        for (int k = 0; k < 4; k++) begin
            setPort(0, 1, 0, 0, 32'h4, 32'h0);
            setPort(1, 1, 0, 0, 32'h8, 32'h0);
            applyStimulus();
            checkVal("t2_m0_gnt", 32'(m0_bus.gnt), 32'((k % 2) == 0));
            checkVal("t2_m1_gnt", 32'(m1_bus.gnt), 32'((k % 2) == 1));
        end

        // Point prio at m1, then m1 locked writes against a waiting m0
        setPort(1, 0, 0, 0, 32'h0, 32'h0);
        setPort(0, 1, 0, 0, 32'h4, 32'h0);
        applyStimulus();
        for (int k = 0; k < 5; k++) begin
            setPort(0, 1, 0, 0, 32'h4, 32'h0);
            setPort(1, 1, 1, 1, 32'h10 + 32'(4 * k), 32'h5A000000 | 32'(k));
            applyStimulus();
            checkVal("t3_m1_gnt", 32'(m1_bus.gnt), 32'(k < 4));
            checkVal("t3_m0_gnt", 32'(m0_bus.gnt), 32'(k == 4));
        end
        setPort(0, 0, 0, 0, 32'h0, 32'h0);
        setPort(1, 0, 0, 0, 32'h0, 32'h0);

        // Misaligned m0 read against m1 read
        setPort(1, 1, 0, 0, 32'h8, 32'h0);
        applyStimulus();
        setPort(0, 1, 0, 0, 32'h6, 32'h0);
        setPort(1, 1, 0, 0, 32'h8, 32'h0);
        applyStimulus();
        checkVal("t4_m0_gnt", 32'(m0_bus.gnt), 32'd0);
        checkVal("t4_m1_gnt", 32'(m1_bus.gnt), 32'd0);
        checkVal("t4_mem_we", 32'(mem_bus.we), 32'd0);
        setPort(0, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus();
        checkVal("t4_m0_err", 32'(m0_bus.err), 32'd1);
        checkVal("t4_m1_gnt", 32'(m1_bus.gnt), 32'd1);
        setPort(1, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus();

        // Reset in the same cycle as an m0 write
        setPort(0, 1, 1, 0, 32'hC, 32'hDEADBEEF);
        rst_v = 1'b0;
        applyStimulus();
        checkVal("t5_mem_we", 32'(mem_bus.we), 32'd0);
        rst_v = 1'b1;
        setPort(0, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus();
        checkVal("t5_m0_rvalid", 32'(m0_bus.rvalid), 32'd0);
        checkVal("t5_m0_err", 32'(m0_bus.err), 32'd0);
        checkVal("t5_m0_rdata", m0_bus.rdata, 32'h0);
        checkVal("t5_m1_rdata", m1_bus.rdata, 32'h0);
        setPort(0, 1, 0, 0, 32'hC, 32'h0);
        applyStimulus();
        setPort(0, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus();
        checkVal("t5_rd_after_rst", m0_bus.rdata, 32'hC0DE0003);

        // Idle cycles: nothing granted, rdata retained
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkVal("t6_m0_gnt", 32'(m0_bus.gnt), 32'd0);
            checkVal("t6_m1_gnt", 32'(m1_bus.gnt), 32'd0);
            checkVal("t6_mem_we", 32'(mem_bus.we), 32'd0);
            checkVal("t6_m0_rvalid", 32'(m0_bus.rvalid), 32'd0);
            checkVal("t6_m0_rdata", m0_bus.rdata, 32'hC0DE0003);
        end

        // Randomized traffic with occasional resets
        resolved[0] = 1'b1;
        resolved[1] = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (resolved[p] || !s_req[p] || $urandom_range(0, 19) == 0) newRandom(p);
            end
            rst_v = ($urandom_range(0, 199) != 0);
            applyStimulus();
        end

        rst_v = 1'b1;
        setPort(0, 0, 0, 0, 32'h0, 32'h0);
        setPort(1, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus();
        applyStimulus();
        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single-port data memory (dmem: clk, we, a, wd, rd; combinational read, write on posedge clk) between requester 0 (CPU load/store unit) and requester 1 (debug/DMA loader).
- Round-robin grant with optional bounded lock for read-modify-write sequences; registers read data back to the granted requester; rejects misaligned word accesses.
- Sits between the two masters and dmem; dmem itself is unchanged.

Parameters:
- AW, 32, address width (byte address).
- DW, 32, data width.
- LOCK_MAX, 4, maximum consecutive cycles one requester may hold the grant via lock before forced release (>=1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- m0_req  input  1  requester 0 access request; hold with fields stable until m0_gnt.
- m0_we  input  1  requester 0 write enable (1 = write, 0 = read).
- m0_lock  input  1  requester 0 asks to keep the grant next cycle.
- m0_addr  input  AW  requester 0 byte address.
- m0_wdata  input  DW  requester 0 write data.
- m0_gnt  output  1  access accepted this cycle (combinational).
- m0_rvalid  output  1  one-cycle pulse, m0_rdata valid.
- m0_rdata  output  DW  registered read data.
- m0_err  output  1  one-cycle pulse, misaligned request rejected.
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as m0_* for requester 1.
- mem_we  output  1  to dmem we.
- mem_a  output  AW  to dmem a.
- mem_wd  output  DW  to dmem wd.
- mem_rd  input  DW  from dmem rd.

Behaviour:
- Clock is clk; reset rst_n is synchronous, active-low. Reset values: gnt 0, rvalid 0, rdata 0, err 0, mem_we 0, mem_a 0, mem_wd 0; priority pointer = m0; lock owner = none; lock counter = 0.
- State:
  - prio: 1 bit, the port favoured on conflict.
  - owner: none/m0/m1.
  - lock_cnt: clog2(LOCK_MAX+1) bits.
- Selection each cycle, combinational:
  - If owner != none and owner's req = 1, owner wins.
  - Else, with one requester active, it wins.
  - Else, with both active, the port named by prio wins.
  - No request: gnt both 0, mem_we 0, mem_a/mem_wd hold 0.
- Alignment: if the winner's addr[1:0] != 0, gnt = 0 and mem_we = 0. err pulses for that port the next cycle. Arbitration state (prio/owner/lock_cnt) updates as if granted, so the other requester is not starved.
- Granted access:
  - mem_a/mem_we/mem_wd driven from the winner in the same cycle.
  - Write commits at that posedge.
  - Read: mem_rd captured into the winner's rdata at that posedge; rvalid = 1 for exactly the next cycle. Latency grant -> rvalid = 1 cycle.
  - rdata holds its value until the next read for that port.
- Round-robin: after any grant without continuing lock, prio = the other port.
- Lock:
  - Winner with lock = 1 and lock_cnt + 1 < LOCK_MAX: owner = winner, lock_cnt increments.
  - Reaching LOCK_MAX consecutive grants: owner cleared, lock_cnt = 0, prio = other port (forced release, even if lock remains 1).
  - Owner dropping req or lock: owner cleared, lock_cnt = 0.
- Only one gnt is asserted in any cycle; mem_we is never 1 without a gnt.
- Reset asserted mid-operation: no write in that cycle (mem_we forced 0), pending rvalid/err suppressed, all state returns to reset values.
- Requester deasserting req before gnt is legal; no side effects.

Test Plan:
- Reset then m0 write addr 0x4 data 0xAABBCCDD, next cycle m0 read 0x4 -> m0_gnt both cycles; m0_rvalid pulse one cycle after read grant with m0_rdata = 0xAABBCCDD.
- m0 and m1 request together for 4 cycles (m0 read 0x4, m1 read 0x8 preloaded 0x11223344) -> grants alternate m0, m1, m0, m1; each rvalid carries its own data, never both in the same cycle.
- m1 holds lock = 1 with continuous writes to 0x10..0x1C while m0 requests, LOCK_MAX = 4 -> m1 granted 4 consecutive cycles, then m0 granted on cycle 5.
- m0 read addr 0x6 -> no gnt, mem_we 0, m0_err pulses next cycle. Concurrent m1 read 0x8 granted the following cycle.
- rst_n low in the same cycle as an m0 write of 0xDEADBEEF to 0xC -> no write; a later read of 0xC returns the prior value. All outputs 0 the cycle after reset.
- Idle (no req) for 3 cycles -> gnt 0, mem_we 0, rvalid 0, rdata retains its last value.
